vliw_fetch_resp: RTL and testbench

Instruction-bundle fetch responder for the `vliw` core. It holds a loadable bundle memory, accepts fetch requests from the core's fetch stage over a valid/ready handshake, and returns bundles in request order after a fixed pipeline latency. A response FIFO absorbs core back-pressure. Benches use the loader port to preload programs before releasing reset on the core.

---
 rtl/vliw_fetch_resp_if.sv | 26 ++
 rtl/vliw_fetch_resp.sv | 144 ++++++++++++++
 tb/tb_vliw_fetch_resp.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_fetch_resp_if.sv
// Fetch request/response handshake bundle between the core fetch stage and the responder.
interface vliw_fetch_resp_if #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned BUNDLE_W = 128
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [BUNDLE_W-1:0] rsp_data;
    logic [ADDR_W-1:0]   rsp_addr;
    logic                rsp_err;

    // Core fetch stage side
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/vliw_fetch_resp.sv
// vliw_fetch_resp: loadable bundle memory, fixed-latency read pipeline and an
// in-order response FIFO that absorbs core back-pressure.
// Optional feature macro: VLIW_FETCH_RANGE_CHECK_EN (out-of-range fetches return
// the NOP bundle with rsp_err; otherwise addresses wrap modulo WORDS).
module vliw_fetch_resp #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WORDS    = 192,
    parameter int unsigned BUNDLE_W = 128,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [BUNDLE_W-1:0] ld_data,
    vliw_fetch_resp_if.slave    fetch
);
    localparam int unsigned MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [BUNDLE_W-1:0] mem_q [WORDS];

    logic [LATENCY-1:0]  pv_q;
    logic [BUNDLE_W-1:0] pd_q [LATENCY];
    logic [ADDR_W-1:0]   pa_q [LATENCY];
    logic [LATENCY-1:0]  pe_q;

    logic [BUNDLE_W-1:0] fd_q [DEPTH];
    logic [ADDR_W-1:0]   fa_q [DEPTH];
    logic [DEPTH-1:0]    fe_q;
    logic [PTR_W-1:0]    wp_q, rp_q;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q;

    logic                accept_c, pop_c, push_c, valid_c;
    logic                rd_err_c, ld_ok_c;
    logic [MEM_AW-1:0]   rd_idx_c, ld_idx_c;
    logic [BUNDLE_W-1:0] rd_data_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifndef VLIW_FETCH_RANGE_CHECK_EN
    function automatic logic [MEM_AW-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(32'(a) % WORDS);
    endfunction
`endif

    assign accept_c = fetch.req_valid && ready_q;
    assign valid_c  = (fcnt_q != '0);
    assign pop_c    = valid_c && fetch.rsp_ready;
    assign push_c   = pv_q[LATENCY-1];

    // Address decode for the fetch read and the loader write
    always_comb begin
`ifdef VLIW_FETCH_RANGE_CHECK_EN
        rd_err_c  = (32'(fetch.req_addr) >= WORDS);
        rd_idx_c  = MEM_AW'(fetch.req_addr);
        ld_ok_c   = ld_en && (32'(ld_addr) < WORDS);
        ld_idx_c  = MEM_AW'(ld_addr);
        rd_data_c = rd_err_c ? '0 : mem_q[rd_idx_c];
`else
        rd_err_c  = 1'b0;
        rd_idx_c  = wrap_idx(fetch.req_addr);
        ld_ok_c   = ld_en;
        ld_idx_c  = wrap_idx(ld_addr);
        rd_data_c = mem_q[rd_idx_c];
`endif
    end

    // Loader write; not gated by reset so programs can be preloaded
    always_ff @(posedge clk) begin
        if (ld_ok_c) mem_q[ld_idx_c] <= ld_data;
    end

    // Pipeline valid bits; reset discards in-flight requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept_c;
            for (int i = 1; i < int'(LATENCY); i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Pipeline payload: stage 1 captures the synchronous read, later stages delay
    always_ff @(posedge clk) begin
        pd_q[0] <= rd_data_c;
        pa_q[0] <= fetch.req_addr;
        pe_q[0] <= rd_err_c;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pd_q[i] <= pd_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
        end
    end

    // FIFO storage written by the last pipeline stage
    always_ff @(posedge clk) begin
        if (push_c) begin
            fd_q[wp_q] <= pd_q[LATENCY-1];
            fa_q[wp_q] <= pa_q[LATENCY-1];
            fe_q[wp_q] <= pe_q[LATENCY-1];
        end
    end

    // Outstanding and FIFO occupancy next-state
    always_comb begin
        cnt_d  = cnt_q;
        fcnt_d = fcnt_q;
        if (accept_c && !pop_c)      cnt_d = cnt_q + CNT_W'(1);
        else if (!accept_c && pop_c) cnt_d = cnt_q - CNT_W'(1);
        if (push_c && !pop_c)        fcnt_d = fcnt_q + CNT_W'(1);
        else if (!push_c && pop_c)   fcnt_d = fcnt_q - CNT_W'(1);
    end

    // Counters, pointers and registered request-ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            fcnt_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            ready_q <= (32'(cnt_d) < DEPTH);
            if (push_c) wp_q <= ptr_inc(wp_q);
            if (pop_c)  rp_q <= ptr_inc(rp_q);
        end
    end

    // Responses present the FIFO head, zeroed while empty
    assign fetch.req_ready = ready_q;
    assign fetch.rsp_valid = valid_c;
    assign fetch.rsp_data  = valid_c ? fd_q[rp_q] : '0;
    assign fetch.rsp_addr  = valid_c ? fa_q[rp_q] : '0;
    assign fetch.rsp_err   = valid_c && fe_q[rp_q];
endmodule

// File: tb/tb_vliw_fetch_resp.sv
// Self-checking bench for vliw_fetch_resp: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch responder.
module tb_vliw_fetch_resp;
    localparam int ADDR_W   = 8;
    localparam int WORDS    = 192;
    localparam int BUNDLE_W = 128;
    localparam int LATENCY  = 2;
    localparam int DEPTH    = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [BUNDLE_W-1:0] data;
        logic                err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                ld_en;
    logic [ADDR_W-1:0]   ld_addr;
    logic [BUNDLE_W-1:0] ld_data;

    vliw_fetch_resp_if #(.ADDR_W(ADDR_W), .BUNDLE_W(BUNDLE_W)) bus ();

    vliw_fetch_resp #(
        .ADDR_W(ADDR_W), .WORDS(WORDS), .BUNDLE_W(BUNDLE_W),
        .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .fetch(bus)
    );

    always #5 clk = ~clk;

    int ntot = 0;
    int nbad = 0;
    logic [BUNDLE_W-1:0] mem_m [WORDS];
    exp_t q[$];

    function automatic logic [BUNDLE_W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic exp_t model_lookup(input logic [ADDR_W-1:0] a);
        exp_t e;
        e.addr = a;
`ifdef VLIW_FETCH_RANGE_CHECK_EN
        if (int'(a) >= WORDS) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = mem_m[int'(a)];
            e.err  = 1'b0;
        end
`else
        e.data = mem_m[int'(a) % WORDS];
        e.err  = 1'b0;
`endif
        return e;
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [BUNDLE_W-1:0] d);
`ifdef VLIW_FETCH_RANGE_CHECK_EN
        if (int'(a) < WORDS) mem_m[int'(a)] = d;
`else
        mem_m[int'(a) % WORDS] = d;
`endif
    endfunction

    // Advance one clock: update the model for what happens at the coming edge,
    // then return at the following falling edge where outputs are sampled.
    task automatic clk_edge();
        bit acc, pop;
        acc = rst && bus.req_valid && bus.req_ready;
        pop = rst && bus.rsp_valid && bus.rsp_ready;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model_lookup(bus.req_addr));
        if (ld_en) model_write(ld_addr, ld_data);
        if (!rst) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            clk_edge();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < WORDS; i++) begin
            ld_en = 1'b1;
            ld_addr = 8'(i);
            ld_data = rand128();
            clk_edge();
        end
        ld_en = 1'b0;
        ntot++; if (bus.req_ready !== 1'b0) begin nbad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        ntot++; if (bus.rsp_valid !== 1'b0) begin nbad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        ntot++; if (bus.rsp_data !== '0) begin nbad++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
        ntot++; if (bus.rsp_addr !== '0) begin nbad++; $display("FAIL reset_rsp_addr got=%h want=0", bus.rsp_addr); end
        ntot++; if (bus.rsp_err !== 1'b0) begin nbad++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
        rst = 1'b1;
        clk_edge();
        ntot++; if (bus.req_ready !== 1'b1) begin nbad++; $display("FAIL release_req_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_basic();
        logic [BUNDLE_W-1:0] a_v, b_v;
        a_v = mem_m[16];
        b_v = mem_m[17];
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 8'h10;
        clk_edge();
        ntot++; if (bus.rsp_valid !== 1'b0) begin nbad++; $display("FAIL basic_lat_n got=%b want=0", bus.rsp_valid); end
        bus.req_addr = 8'h11;
        clk_edge();
        bus.req_valid = 1'b0;
        ntot++; if (bus.rsp_valid !== 1'b0) begin nbad++; $display("FAIL basic_lat_n1 got=%b want=0", bus.rsp_valid); end
        clk_edge();
        ntot++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== a_v || bus.rsp_addr !== 8'h10)
            begin nbad++; $display("FAIL basic_a got=%b/%h/%h want=1/%h/10", bus.rsp_valid, bus.rsp_data, bus.rsp_addr, a_v); end
        clk_edge();
        ntot++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== b_v || bus.rsp_addr !== 8'h11)
            begin nbad++; $display("FAIL basic_b got=%b/%h/%h want=1/%h/11", bus.rsp_valid, bus.rsp_data, bus.rsp_addr, b_v); end
        clk_edge();
        ntot++; if (bus.rsp_valid !== 1'b0) begin nbad++; $display("FAIL basic_empty got=%b want=0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        int idx, pops;
        bit acc;
        idx = 0;
        pops = 0;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (idx < 6);
            bus.req_addr = 8'(8'h30 + idx);
            acc = bus.req_valid && bus.req_ready;
            clk_edge();
            if (acc) idx++;
        end
        bus.req_valid = 1'b0;
        ntot++; if (idx != DEPTH) begin nbad++; $display("FAIL bp_accepted got=%0d want=%0d", idx, DEPTH); end
        ntot++; if (bus.req_ready !== 1'b0) begin nbad++; $display("FAIL bp_ready_low got=%b want=0", bus.req_ready); end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && pops < 6; c++) begin
            bus.req_valid = (idx < 6);
            bus.req_addr = 8'(8'h30 + idx);
            if (bus.rsp_valid === 1'b1) begin
                ntot++;
                if (q.size() == 0 || bus.rsp_addr !== 8'(8'h30 + pops) || bus.rsp_data !== q[0].data)
                    begin nbad++; $display("FAIL bp_order got=%h/%h want=%h", bus.rsp_addr, bus.rsp_data, 8'(8'h30 + pops)); end
                pops++;
            end
            acc = bus.req_valid && bus.req_ready;
            clk_edge();
            if (acc) idx++;
        end
        bus.req_valid = 1'b0;
        ntot++; if (pops != 6 || idx != 6) begin nbad++; $display("FAIL bp_drain got=%0d/%0d want=6/6", pops, idx); end
    endtask

    task automatic test_read_during_write();
        logic [BUNDLE_W-1:0] c_v, d_v;
        bit ok;
        d_v = mem_m[32];
        c_v = rand128();
        bus.rsp_ready = 1'b1;
        ld_en = 1'b1;
        ld_addr = 8'h20;
        ld_data = c_v;
        bus.req_valid = 1'b1;
        bus.req_addr = 8'h20;
        clk_edge();
        ld_en = 1'b0;
        bus.req_valid = 1'b0;
        wait_valid(10, ok);
        ntot++; if (!ok || bus.rsp_data !== d_v || bus.rsp_addr !== 8'h20)
            begin nbad++; $display("FAIL rdw_old got=%b/%h want=%h", ok, bus.rsp_data, d_v); end
        clk_edge();
        bus.req_valid = 1'b1;
        clk_edge();
        bus.req_valid = 1'b0;
        wait_valid(10, ok);
        ntot++; if (!ok || bus.rsp_data !== c_v)
            begin nbad++; $display("FAIL rdw_new got=%b/%h want=%h", ok, bus.rsp_data, c_v); end
        clk_edge();
    endtask

    task automatic test_reset_flush();
        logic [BUNDLE_W-1:0] a_v;
        bit ok, spur;
        a_v = mem_m[16];
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr = 8'(8'h40 + i);
            clk_edge();
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        clk_edge();
        ntot++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.req_ready !== 1'b0)
            begin nbad++; $display("FAIL flush_outputs got=%b/%h/%b want=0/0/0", bus.rsp_valid, bus.rsp_data, bus.req_ready); end
        rst = 1'b1;
        clk_edge();
        ntot++; if (bus.req_ready !== 1'b1) begin nbad++; $display("FAIL flush_ready got=%b want=1", bus.req_ready); end
        spur = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid !== 1'b0) spur = 1'b1;
            clk_edge();
        end
        ntot++; if (spur) begin nbad++; $display("FAIL flush_discard got=1 want=0"); end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 8'h10;
        clk_edge();
        bus.req_valid = 1'b0;
        wait_valid(10, ok);
        ntot++; if (!ok || bus.rsp_data !== a_v || bus.rsp_addr !== 8'h10)
            begin nbad++; $display("FAIL flush_mem got=%b/%h want=%h", ok, bus.rsp_data, a_v); end
        clk_edge();
    endtask

    task automatic test_range();
        logic [BUNDLE_W-1:0] exp_d;
        logic exp_e;
        bit ok;
        bus.rsp_ready = 1'b1;
        ld_en = 1'b1;
        ld_addr = 8'hC5;
        ld_data = rand128();
        clk_edge();
        ld_en = 1'b0;
`ifdef VLIW_FETCH_RANGE_CHECK_EN
        exp_d = '0;
        exp_e = 1'b1;
`else
        exp_d = mem_m[5];
        exp_e = 1'b0;
`endif
        bus.req_valid = 1'b1;
        bus.req_addr = 8'hC5;
        clk_edge();
        bus.req_valid = 1'b0;
        wait_valid(10, ok);
        ntot++; if (!ok || bus.rsp_data !== exp_d || bus.rsp_err !== exp_e || bus.rsp_addr !== 8'hC5)
            begin nbad++; $display("FAIL range_c5 got=%b/%h/%b/%h want=%h/%b/c5", ok, bus.rsp_data, bus.rsp_err, bus.rsp_addr, exp_d, exp_e); end
        clk_edge();
        exp_d = mem_m[5];
        bus.req_valid = 1'b1;
        bus.req_addr = 8'h05;
        clk_edge();
        bus.req_valid = 1'b0;
        wait_valid(10, ok);
        ntot++; if (!ok || bus.rsp_data !== exp_d || bus.rsp_err !== 1'b0)
            begin nbad++; $display("FAIL range_05 got=%b/%h/%b want=%h/0", ok, bus.rsp_data, bus.rsp_err, exp_d); end
        clk_edge();
    endtask

    task automatic test_random();
        int sent, cyc;
        bit stall_prev;
        logic [BUNDLE_W-1:0] hd;
        logic [ADDR_W-1:0] ha;
        logic he;
        sent = 0;
        cyc = 0;
        stall_prev = 1'b0;
        hd = '0;
        ha = '0;
        he = 1'b0;
        while (sent < 200 && cyc < 5000) begin
            if (stall_prev) begin
                ntot++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== hd || bus.rsp_addr !== ha || bus.rsp_err !== he)
                    begin nbad++; $display("FAIL rnd_stall got=%b/%h/%h want=1/%h/%h", bus.rsp_valid, bus.rsp_addr, bus.rsp_data, ha, hd); end
            end
            ntot++;
            if (bus.req_ready !== 1'((q.size() < DEPTH)))
                begin nbad++; $display("FAIL rnd_ready got=%b want=%b", bus.req_ready, (q.size() < DEPTH)); end
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_addr = 8'($urandom_range(0, 255));
            bus.rsp_ready = $urandom_range(0, 1) == 1;
            ld_en = ($urandom_range(0, 9) == 0);
            ld_addr = 8'($urandom_range(0, 255));
            ld_data = rand128();
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
                ntot++;
                if (q.size() == 0) begin
                    nbad++; $display("FAIL rnd_extra got=%h want=none", bus.rsp_addr);
                end else if (bus.rsp_addr !== q[0].addr || bus.rsp_data !== q[0].data || bus.rsp_err !== q[0].err) begin
                    nbad++; $display("FAIL rnd_data got=%h/%h/%b want=%h/%h/%b", bus.rsp_addr, bus.rsp_data, bus.rsp_err, q[0].addr, q[0].data, q[0].err);
                end
            end
            stall_prev = (bus.rsp_valid === 1'b1) && !bus.rsp_ready;
            hd = bus.rsp_data;
            ha = bus.rsp_addr;
            he = bus.rsp_err;
            if (bus.req_valid && bus.req_ready) sent++;
            clk_edge();
            cyc++;
        end
        ntot++; if (sent != 200) begin nbad++; $display("FAIL rnd_budget got=%0d want=200", sent); end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        ld_en = 1'b0;
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                ntot++;
                if (bus.rsp_addr !== q[0].addr || bus.rsp_data !== q[0].data || bus.rsp_err !== q[0].err)
                    begin nbad++; $display("FAIL rnd_drain got=%h/%h want=%h/%h", bus.rsp_addr, bus.rsp_data, q[0].addr, q[0].data); end
            end
            clk_edge();
        end
        ntot++; if (q.size() != 0 || bus.rsp_valid !== 1'b0)
            begin nbad++; $display("FAIL rnd_final got=%0d/%b want=0/0", q.size(), bus.rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_read_during_write();
        test_reset_flush();
        test_range();
        test_random();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
